// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the multiply/divide unit.
//  - muldiv_op_t : operation code presented to mips_muldiv_unit
//  - ALU_*       : alucontrol encodings that select a muldiv operation
//  - muldiv_ctx_t: per-operation sign/corner-case context latched at start
package mips_pkg;

   typedef enum logic [2:0] {
      NOP   = 3'd0,
      MULT  = 3'd1,
      MULTU = 3'd2,
      DIV   = 3'd3,
      DIVU  = 3'd4,
      MTHI  = 3'd5,
      MTLO  = 3'd6
   } muldiv_op_t;

   localparam logic [4:0] ALU_MULT  = 5'b00111;
   localparam logic [4:0] ALU_MULTU = 5'b01000;
   localparam logic [4:0] ALU_DIV   = 5'b01111;
   localparam logic [4:0] ALU_DIVU  = 5'b10000;
   localparam logic [4:0] ALU_MTHI  = 5'b10001;
   localparam logic [4:0] ALU_MTLO  = 5'b10010;

   typedef struct packed {
      logic is_div;    // datapath runs shift-subtract instead of shift-add
      logic neg_res;   // negate product / quotient at the end
      logic neg_rem;   // remainder takes the sign of a negative dividend
      logic div_zero;  // divisor was zero: quotient forced to all ones
   } muldiv_ctx_t;

   function automatic muldiv_op_t alu_to_muldiv(input logic [4:0] alucontrol);
      case (alucontrol)
         ALU_MULT:  return MULT;
         ALU_MULTU: return MULTU;
         ALU_DIV:   return DIV;
         ALU_DIVU:  return DIVU;
         ALU_MTHI:  return MTHI;
         ALU_MTLO:  return MTLO;
         default:   return NOP;
      endcase
   endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Execute-stage request/result bundle between the core and the muldiv unit.
//  master (core): drives start, op, a, b; reads busy, done, hi, lo
//  slave  (unit): the reverse
import mips_pkg::*;

interface mips_muldiv_unit_if #(parameter int WIDTH = 32);
   logic             start;
   muldiv_op_t       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, input  busy, done, hi, lo);
   modport slave  (input  start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_unit_step.sv
// muldiv_step: one combinational iteration of the shared datapath.
//  is_div  in   select restoring-divide step (1) or shift-add multiply step (0)
//  acc     in   2*WIDTH working register
//               multiply: {partial product high, remaining multiplier bits}
//               divide  : {partial remainder, dividend bits / quotient bits}
//  opnd    in   multiplicand magnitude or divisor magnitude
//  acc_nxt out  working register after this iteration
module muldiv_step #(parameter int WIDTH = 32) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   opnd,
   output logic [2*WIDTH-1:0] acc_nxt
);
   logic [WIDTH:0] sum;
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;

   always_comb begin
      // multiply: add multiplicand when the current multiplier bit is set, keep the carry
      sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      // divide: bring the next dividend bit into the remainder and try the subtract
      shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      trial   = shifted - {1'b0, opnd};
      if (is_div) begin
         // shifted < 2*divisor, so trial's top bit is a clean borrow flag
         if (!trial[WIDTH]) acc_nxt = {trial[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
         else               acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
         acc_nxt = {sum, acc[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative multiply/divide unit owning HI/LO.
//  clk        in  rising-edge clock
//  reset      in  asynchronous active-low reset
//  clk_enable in  global stall; 0 freezes all state including done
//  bus        slave side of mips_muldiv_unit_if (start/op/a/b in, busy/done/hi/lo out)
// Operands are converted to magnitudes on acceptance, run through WIDTH
// iterations of muldiv_step, then sign-corrected and written to HI/LO in FIX.
import mips_pkg::*;

module mips_muldiv_unit #(parameter int WIDTH = 32) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   mips_muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc, acc_nxt;
   logic [WIDTH-1:0]   opnd, hi_q, lo_q;
   muldiv_ctx_t        ctx;
   logic               busy_q, done_q;

   logic               signed_op, sa, sb;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div (ctx.is_div),
      .acc    (acc),
      .opnd   (opnd),
      .acc_nxt(acc_nxt)
   );

   always_comb begin
      signed_op = (bus.op == MULT) || (bus.op == DIV);
      sa        = signed_op & bus.a[WIDTH-1];
      sb        = signed_op & bus.b[WIDTH-1];
      // 0x80000000 negates to itself, which is the correct unsigned magnitude
      mag_a     = sa ? -bus.a : bus.a;
      mag_b     = sb ? -bus.b : bus.b;
   end

   always_comb begin
      prod_fix = ctx.neg_res ? -acc : acc;
      quo_fix  = ctx.div_zero ? '1 : (ctx.neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      // with a zero divisor the remainder is |a|, so the sign fix restores a exactly
      rem_fix  = ctx.neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         ctx    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (clk_enable) begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  case (bus.op)
                     MTHI: hi_q <= bus.a;
                     MTLO: lo_q <= bus.a;
                     MULT, MULTU, DIV, DIVU: begin
                        if ((bus.op == DIV) || (bus.op == DIVU)) begin
                           acc  <= {{WIDTH{1'b0}}, mag_a};
                           opnd <= mag_b;
                        end else begin
                           acc  <= {{WIDTH{1'b0}}, mag_b};
                           opnd <= mag_a;
                        end
                        ctx.is_div   <= (bus.op == DIV) || (bus.op == DIVU);
                        ctx.neg_res  <= sa ^ sb;
                        ctx.neg_rem  <= sa;
                        ctx.div_zero <= (bus.b == '0);
                        cnt          <= '0;
                        busy_q       <= 1'b1;
                        state        <= CALC;
                     end
                     default: ;
                  endcase
               end
            end
            CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(WIDTH-1)) state <= FIX;
            end
            FIX: begin
               if (ctx.is_div) begin
                  lo_q <= quo_fix;
                  hi_q <= rem_fix;
               end else begin
                  {hi_q, lo_q} <= prod_fix;
               end
               done_q <= 1'b1;
               busy_q <= 1'b0;
               cnt    <= '0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule
